// File: rtl/sc_stream_decoder_pkg.sv
// Shared types and sizing helpers for the stochastic-computing stream decoder.
package sc_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } sc_dec_state_e;

    // One extra bit so a window of all ones reads back as exactly 2**len_log2.
    function automatic int sc_cnt_w(input int len_log2);
        return len_log2 + 32'sd1;
    endfunction

endpackage

// File: rtl/sc_stream_decoder_if.sv
// Sample input, control and valid/ready result port of the stream decoder.
interface sc_stream_decoder_if #(
    parameter int NUM_STREAMS = 2,
    parameter int LEN_LOG2    = 8
);
    import sc_pkg::*;

    localparam int CW = sc_cnt_w(LEN_LOG2);

    logic                      start;
    logic                      in_valid;
    logic [NUM_STREAMS-1:0]    in_bits;
    logic                      busy;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_STREAMS*CW-1:0] out_count;
    logic [CW-1:0]             out_both;
    logic                      overrun;

    modport master (
        output start, in_valid, in_bits, out_ready,
        input  busy, out_valid, out_count, out_both, overrun
    );

    modport slave (
        input  start, in_valid, in_bits, out_ready,
        output busy, out_valid, out_count, out_both, overrun
    );

endinterface

// File: rtl/sc_stream_decoder_ones.sv
// Single ones accumulator; clear has priority over counting.
module sc_ones_counter
    import sc_pkg::*;
#(
    parameter int LEN_LOG2 = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_clr,
    input  logic                          i_en,
    input  logic                          i_bit,
    output logic [sc_cnt_w(LEN_LOG2)-1:0] o_count
);

    localparam int CW = sc_cnt_w(LEN_LOG2);
    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] r_acc;

    // Accumulate one per enabled sample whose bit is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= {CW{1'b0}};
        end else if (i_clr) begin
            r_acc <= {CW{1'b0}};
        end else if (i_en && i_bit) begin
            r_acc <= r_acc + ONE;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_count = r_acc;

endmodule

// File: rtl/sc_stream_decoder.sv
// Converts unipolar bitstreams back to binary counts over fixed windows,
// with an overlap count of streams 0 and 1 and a valid/ready result port.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int NUM_STREAMS = 2,
    parameter int LEN_LOG2    = 8,
    parameter int CONTINUOUS  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sc_stream_decoder_if.slave bus
);

    localparam int CW = sc_cnt_w(LEN_LOG2);
    localparam int NACC = NUM_STREAMS + 1;
    localparam logic [LEN_LOG2-1:0] LAST_SAMPLE = {LEN_LOG2{1'b1}};
    localparam logic [LEN_LOG2-1:0] SAMPLE_ONE  = {{(LEN_LOG2-1){1'b0}}, 1'b1};
    localparam bit CONT = (CONTINUOUS != 32'sd0);

    sc_dec_state_e             r_state;
    logic [LEN_LOG2-1:0]       r_sample;
    logic                      r_busy;
    logic                      r_out_valid;
    logic                      r_overrun;
    logic [NUM_STREAMS*CW-1:0] r_count;
    logic [CW-1:0]             r_both;

    logic [NACC-1:0]           w_bit;
    logic [CW-1:0]             w_acc [NACC];
    logic [NUM_STREAMS*CW-1:0] w_final_count;
    logic [CW-1:0]             w_final_both;
    logic                      w_sample_en;
    logic                      w_complete;
    logic                      w_clr;
    logic                      w_xfer;
    logic                      w_load;
    logic                      w_drop;

    assign w_bit[NUM_STREAMS-1:0] = bus.in_bits;
    assign w_bit[NUM_STREAMS]     = bus.in_bits[0] & bus.in_bits[1];

    // start pre-empts the sample on its own cycle, and with it any completion.
    assign w_sample_en = (r_state == COUNT) & bus.in_valid & ~bus.start;
    assign w_complete  = w_sample_en & (r_sample == LAST_SAMPLE);
    assign w_clr       = bus.start | w_complete;
    assign w_xfer      = r_out_valid & bus.out_ready;
    assign w_load      = w_complete & (~r_out_valid | bus.out_ready);
    assign w_drop      = w_complete & r_out_valid & ~bus.out_ready;

    for (genvar g = 0; g < NACC; g++) begin : g_acc
        sc_ones_counter #(
            .LEN_LOG2 (LEN_LOG2)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clr   (w_clr),
            .i_en    (w_sample_en),
            .i_bit   (w_bit[g]),
            .o_count (w_acc[g])
        );
    end

    // Final totals must include the completing sample, which the accumulators have not seen yet.
    always_comb begin
        w_final_count = {(NUM_STREAMS*CW){1'b0}};
        for (int i = 0; i < NUM_STREAMS; i++) begin
            w_final_count[i*CW +: CW] = w_acc[i] + {{(CW-1){1'b0}}, w_bit[i]};
        end
        w_final_both = w_acc[NUM_STREAMS] + {{(CW-1){1'b0}}, w_bit[NUM_STREAMS]};
    end

    // Window FSM with the sample counter and the registered busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_sample <= {LEN_LOG2{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state  <= COUNT;
                        r_busy   <= 1'b1;
                        r_sample <= {LEN_LOG2{1'b0}};
                    end else begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_sample <= r_sample;
                    end
                end
                COUNT: begin
                    if (bus.start) begin
                        r_state  <= COUNT;
                        r_busy   <= 1'b1;
                        r_sample <= {LEN_LOG2{1'b0}};
                    end else if (w_complete) begin
                        r_state  <= CONT ? COUNT : IDLE;
                        r_busy   <= CONT;
                        r_sample <= {LEN_LOG2{1'b0}};
                    end else if (bus.in_valid) begin
                        r_state  <= COUNT;
                        r_busy   <= 1'b1;
                        r_sample <= r_sample + SAMPLE_ONE;
                    end else begin
                        r_state  <= COUNT;
                        r_busy   <= 1'b1;
                        r_sample <= r_sample;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_sample <= {LEN_LOG2{1'b0}};
                end
            endcase
        end
    end

    // Result registers, output handshake and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_count     <= {(NUM_STREAMS*CW){1'b0}};
            r_both      <= {CW{1'b0}};
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_count     <= w_final_count;
                r_both      <= w_final_both;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.overrun   = r_overrun;
    assign bus.out_count = r_count;
    assign bus.out_both  = r_both;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Drives a one-shot and a continuous decoder with the same stimulus and checks both
// against a window-level reference model plus directed corner cases.
module tb_sc_stream_decoder;

    localparam int N = 256;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [1:0] in_bits;
    logic       out_ready;

    int n_checks;
    int n_errors;

    sc_stream_decoder_if #(.NUM_STREAMS(2), .LEN_LOG2(8)) if0 ();
    sc_stream_decoder_if #(.NUM_STREAMS(2), .LEN_LOG2(8)) if1 ();

    assign if0.start = start;  assign if0.in_valid = in_valid;
    assign if0.in_bits = in_bits;  assign if0.out_ready = out_ready;
    assign if1.start = start;  assign if1.in_valid = in_valid;
    assign if1.in_bits = in_bits;  assign if1.out_ready = out_ready;

    sc_stream_decoder #(.NUM_STREAMS(2), .LEN_LOG2(8), .CONTINUOUS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    sc_stream_decoder #(.NUM_STREAMS(2), .LEN_LOG2(8), .CONTINUOUS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per decoder, window progress and the visible result.
    int m_armed [2];
    int m_n     [2];
    int m_s0    [2];
    int m_s1    [2];
    int m_sb    [2];
    int m_ov    [2];
    int m_r0    [2];
    int m_r1    [2];
    int m_rb    [2];
    int m_orun  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input int d);
        bit done;
        int f0, f1, fb;
        done = 1'b0;
        f0 = 0; f1 = 0; fb = 0;
        if (!rst_n) begin
            m_armed[d] = 0; m_n[d] = 0; m_s0[d] = 0; m_s1[d] = 0; m_sb[d] = 0;
            m_ov[d] = 0; m_r0[d] = 0; m_r1[d] = 0; m_rb[d] = 0; m_orun[d] = 0;
        end else begin
            if (start) begin
                m_armed[d] = 1; m_n[d] = 0; m_s0[d] = 0; m_s1[d] = 0; m_sb[d] = 0;
            end else if (m_armed[d] != 0 && in_valid) begin
                m_s0[d] += int'(in_bits[0]);
                m_s1[d] += int'(in_bits[1]);
                m_sb[d] += int'(in_bits[0] & in_bits[1]);
                m_n[d]++;
                if (m_n[d] == N) begin
                    done = 1'b1;
                    f0 = m_s0[d]; f1 = m_s1[d]; fb = m_sb[d];
                    m_s0[d] = 0; m_s1[d] = 0; m_sb[d] = 0; m_n[d] = 0;
                    m_armed[d] = d;
                end
            end
            if (done) begin
                if (m_ov[d] == 0 || out_ready) begin
                    m_ov[d] = 1; m_r0[d] = f0; m_r1[d] = f1; m_rb[d] = fb;
                end else begin
                    m_orun[d] = 1;
                end
            end else if (m_ov[d] != 0 && out_ready) begin
                m_ov[d] = 0;
            end
        end
    endtask

    function automatic logic [31:0] model_vec(input int d);
        logic [8:0] c0, c1, cb;
        c0 = 9'(m_r0[d]); c1 = 9'(m_r1[d]); cb = 9'(m_rb[d]);
        return {2'b00, (m_armed[d] != 0), (m_ov[d] != 0), (m_orun[d] != 0), c1, c0, cb};
    endfunction

    // One clock: advance the model with the applied inputs, then compare after the edge.
    task automatic step();
        model_update(0);
        model_update(1);
        @(posedge clk);
        #1;
        check("dut0 vs model", {2'b00, if0.busy, if0.out_valid, if0.overrun, if0.out_count, if0.out_both},
              model_vec(0));
        check("dut1 vs model", {2'b00, if1.busy, if1.out_valid, if1.overrun, if1.out_count, if1.out_both},
              model_vec(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_bits = 2'b00; out_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1; in_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int count, input logic [1:0] bits);
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1; in_bits = bits;
            step();
        end
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       in_valid;
        logic [1:0] bits;
        logic       exp_busy;
        logic       exp_valid;
    } vec_t;

    vec_t vt [6];

    initial begin
        int n_res;
        int gaps;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_bits = 2'b00; out_ready = 1'b0;

        vt[0] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            rst_n = vt[i].rst_n; start = vt[i].start;
            in_valid = vt[i].in_valid; in_bits = vt[i].bits;
            step();
            check($sformatf("vec%0d busy", i), {31'd0, if0.busy}, {31'd0, vt[i].exp_busy});
            check($sformatf("vec%0d out_valid", i), {31'd0, if0.out_valid}, {31'd0, vt[i].exp_valid});
        end
        check("reset outputs", {if0.overrun, if0.out_count, if0.out_both}, 32'd0);

        // All-ones window reaches exactly N in every counter.
        do_reset();
        pulse_start();
        feed(255, 2'b11);
        check("t1 not early", {31'd0, if0.out_valid}, 32'd0);
        feed(1, 2'b11);
        check("t1 valid", {31'd0, if0.out_valid}, 32'd1);
        check("t1 busy", {31'd0, if0.busy}, 32'd0);
        check("t1 count", {14'd0, if0.out_count}, {14'd0, 9'd256, 9'd256});
        check("t1 both", {23'd0, if0.out_both}, 32'd256);
        out_ready = 1'b1;
        step();
        check("t1 consumed", {31'd0, if0.out_valid}, 32'd0);
        out_ready = 1'b0;

        // Gapped stream: valid on even cycles, densities 1/4 and 1/2.
        pulse_start();
        for (int c = 0; c < 512; c++) begin
            in_valid = (c % 2 == 0);
            in_bits = {((c / 2) % 2 == 0), ((c / 2) % 4 == 0)};
            step();
        end
        in_valid = 1'b0;
        check("t2 valid", {31'd0, if0.out_valid}, 32'd1);
        check("t2 count0", {23'd0, if0.out_count[8:0]}, 32'd64);
        check("t2 count1", {23'd0, if0.out_count[17:9]}, 32'd128);
        check("t2 both", {23'd0, if0.out_both}, 32'd64);

        // Continuous decoder: three back-to-back windows drained every cycle.
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        n_res = 0; gaps = 0;
        for (int i = 0; i < 3 * N; i++) begin
            in_valid = 1'b1; in_bits = 2'b01;
            step();
            if (!if1.busy) gaps++;
            if (if1.out_valid) begin
                n_res++;
                check("t3 result", {5'd0, if1.out_count, if1.out_both}, {5'd0, 9'd0, 9'd256, 9'd0});
            end
        end
        in_valid = 1'b0;
        check("t3 results", n_res, 32'd3);
        check("t3 gaps", gaps, 32'd0);
        check("t3 overrun", {31'd0, if1.overrun}, 32'd0);

        // Second completion while the first result is stalled is dropped.
        do_reset();
        pulse_start();
        feed(N, 2'b11);
        pulse_start();
        feed(N, 2'b01);
        check("t4 held count", {14'd0, if0.out_count}, {14'd0, 9'd256, 9'd256});
        check("t4 held both", {23'd0, if0.out_both}, 32'd256);
        check("t4 overrun", {31'd0, if0.overrun}, 32'd1);
        out_ready = 1'b1;
        step();
        check("t4 drained", {31'd0, if0.out_valid}, 32'd0);
        check("t4 sticky", {31'd0, if0.overrun}, 32'd1);
        out_ready = 1'b0;

        // Restart mid-window discards the partial counts.
        do_reset();
        pulse_start();
        feed(100, 2'b11);
        pulse_start();
        feed(255, 2'b10);
        check("t5 no early result", {31'd0, if0.out_valid}, 32'd0);
        feed(1, 2'b10);
        check("t5 count1", {23'd0, if0.out_count[17:9]}, 32'd256);
        check("t5 count0", {23'd0, if0.out_count[8:0]}, 32'd0);
        check("t5 both", {23'd0, if0.out_both}, 32'd0);

        // Reset mid-window returns everything to idle.
        do_reset();
        pulse_start();
        feed(100, 2'b11);
        rst_n = 1'b0;
        step();
        check("t5 rst dut0", {2'b00, if0.busy, if0.out_valid, if0.overrun, if0.out_count, if0.out_both}, 32'd0);
        check("t5 rst dut1", {2'b00, if1.busy, if1.out_valid, if1.overrun, if1.out_count, if1.out_both}, 32'd0);
        rst_n = 1'b1;
        feed(5, 2'b11);
        check("t5 stays idle", {31'd0, if0.busy}, 32'd0);

        // Completion on the same edge as an accepted transfer.
        do_reset();
        pulse_start();
        feed(N, 2'b11);
        check("t6 first valid", {31'd0, if0.out_valid}, 32'd1);
        pulse_start();
        feed(N - 1, 2'b01);
        out_ready = 1'b1;
        feed(1, 2'b01);
        check("t6 valid kept", {31'd0, if0.out_valid}, 32'd1);
        check("t6 new count", {14'd0, if0.out_count}, {14'd0, 9'd0, 9'd256});
        check("t6 overrun", {31'd0, if0.overrun}, 32'd0);
        step();
        check("t6 drained", {31'd0, if0.out_valid}, 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 999) != 0);
            start     = ($urandom_range(0, 399) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_bits   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
